// File: rtl/sci_cnt_pkg.sv
// sci_cnt_pkg: shared types, constants and the exponent helper for the
// scientific-notation event counter. Both the RTL and any model can use it.
//   bcd_t       - one BCD digit
//   BCD_MAX     - largest legal digit value
//   E_GLYPH_BCD - code the seven_seg decoders render as 'E'
//   exp_of()    - display exponent for a count (zero-extended to 16 digits)
package sci_cnt_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX     = 4'd9;
    localparam bcd_t E_GLYPH_BCD = 4'hE;
    localparam int   MAX_DIGITS  = 16;

    // Finds the most significant nonzero digit (0 for an all-zero count),
    // then shifts it to the top of the mantissa window.
    function automatic bcd_t exp_of(input logic [4*MAX_DIGITS-1:0] count,
                                    input int mant_digits);
        int msd;
        msd = 0;
        for (int k = 0; k < MAX_DIGITS; k++)
            if (count[4*k +: 4] != 4'd0) msd = k;
        if (msd > mant_digits - 1)
            return bcd_t'(msd - (mant_digits - 1));
        return 4'd0;
    endfunction

endpackage

// File: rtl/sci_event_counter_if.sv
// sci_event_counter_if: control strobes and readout bus of the event counter.
//   inc, clr, hold                   - driven by the master (event source)
//   count_bcd, mant_bcd, exp_bcd,
//   ovf, disp_upd                    - driven by the slave (counter)
interface sci_event_counter_if
    import sci_cnt_pkg::*;
#(
    parameter int NUM_DIGITS  = 11,
    parameter int MANT_DIGITS = 2
);
    logic                     inc;
    logic                     clr;
    logic                     hold;
    logic [4*NUM_DIGITS-1:0]  count_bcd;
    logic [4*MANT_DIGITS-1:0] mant_bcd;
    bcd_t                     exp_bcd;
    logic                     ovf;
    logic                     disp_upd;

    modport master (
        output inc, clr, hold,
        input  count_bcd, mant_bcd, exp_bcd, ovf, disp_upd
    );

    modport slave (
        input  inc, clr, hold,
        output count_bcd, mant_bcd, exp_bcd, ovf, disp_upd
    );
endinterface

// File: rtl/sci_event_counter_bcd_digit.sv
// bcd_digit: one decade of the BCD counter.
//   clk, rst - clock, synchronous active-low reset
//   ci       - advance this digit (all lower digits are 9 and inc is set)
//   clr      - synchronous clear
//   q        - digit value, always 0..9
//   co       - carry into the next decade (combinational, same cycle)
module bcd_digit
    import sci_cnt_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ci,
    input  logic clr,
    output bcd_t q,
    output logic co
);
    always_ff @(posedge clk) begin
        if (!rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (ci)
            q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end

    // Combinational carry lets the whole chain settle within one cycle.
    assign co = ci & (q == BCD_MAX);
endmodule

// File: rtl/sci_event_counter.sv
// sci_event_counter: N-digit BCD event counter with mantissa/exponent readout.
//   clk, rst - clock, synchronous active-low reset
//   bus      - sci_event_counter_if.slave: inc/clr/hold in; count_bcd,
//              mant_bcd, exp_bcd, ovf, disp_upd out
// Build option: SCI_CNT_SATURATE_EN - count sticks at all-9s instead of
// wrapping to zero on the terminal increment (ovf is set either way).
module sci_event_counter
    import sci_cnt_pkg::*;
#(
    parameter int NUM_DIGITS  = 11,
    parameter int MANT_DIGITS = 2
)(
    input  logic                      clk,
    input  logic                      rst,
    sci_event_counter_if.slave        bus
);
    logic [NUM_DIGITS:0]      carry;
    logic [4*NUM_DIGITS-1:0]  count_q;
    logic                     ovf_set;

`ifdef SCI_CNT_SATURATE_EN
    logic all_nines;
    always_comb begin
        all_nines = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (count_q[4*k +: 4] != BCD_MAX) all_nines = 1'b0;
    end
    // Suppress the terminal increment so the chain never wraps.
    assign carry[0] = bus.inc & ~all_nines;
    assign ovf_set  = bus.inc & all_nines;
    wire unused_msd_co = carry[NUM_DIGITS];
`else
    assign carry[0] = bus.inc;
    // Carry out of the top decade means every digit was 9.
    assign ovf_set  = carry[NUM_DIGITS];
`endif

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk (clk),
            .rst (rst),
            .ci  (carry[g]),
            .clr (bus.clr),
            .q   (count_q[4*g +: 4]),
            .co  (carry[g+1])
        );
    end

    // Display path works from the registered count, so it trails by a cycle.
    bcd_t                     exp_c;
    logic [4*NUM_DIGITS-1:0]  shifted;
    logic [4*MANT_DIGITS-1:0] mant_c;

    assign exp_c   = exp_of(64'(count_q), MANT_DIGITS);
    assign shifted = count_q >> {exp_c, 2'b00};
    assign mant_c  = shifted[4*MANT_DIGITS-1:0];

    logic [4*MANT_DIGITS-1:0] mant_q;
    bcd_t                     exp_q;
    logic                     ovf_q;
    logic                     upd_q;

    always_ff @(posedge clk) begin
        if (!rst || bus.clr) begin
            mant_q <= '0;
            exp_q  <= '0;
            ovf_q  <= 1'b0;
            upd_q  <= 1'b0;
        end else begin
            if (ovf_set) ovf_q <= 1'b1;
            if (!bus.hold) begin
                mant_q <= mant_c;
                exp_q  <= exp_c;
            end
            upd_q <= !bus.hold && ((mant_c != mant_q) || (exp_c != exp_q));
        end
    end

    assign bus.count_bcd = count_q;
    assign bus.mant_bcd  = mant_q;
    assign bus.exp_bcd   = exp_q;
    assign bus.ovf       = ovf_q;
    assign bus.disp_upd  = upd_q;
endmodule

// File: tb/tb_sci_event_counter.sv
// Bench for sci_event_counter: three instances (11/2, 4/2, 5/3 digits) driven
// one at a time; a decimal integer model predicts every instance each edge and
// expectations are queued at drive time and compared after the edge.
module tb_sci_event_counter;

    localparam int ND[3] = '{11, 4, 5};
    localparam int MD[3] = '{2, 2, 3};

    logic clk;
    logic rst_r[3], inc_r[3], clr_r[3], hold_r[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sci_event_counter_if #(.NUM_DIGITS(11), .MANT_DIGITS(2)) ifa ();
    sci_event_counter_if #(.NUM_DIGITS(4),  .MANT_DIGITS(2)) ifb ();
    sci_event_counter_if #(.NUM_DIGITS(5),  .MANT_DIGITS(3)) ifc ();

    assign ifa.inc = inc_r[0]; assign ifa.clr = clr_r[0]; assign ifa.hold = hold_r[0];
    assign ifb.inc = inc_r[1]; assign ifb.clr = clr_r[1]; assign ifb.hold = hold_r[1];
    assign ifc.inc = inc_r[2]; assign ifc.clr = clr_r[2]; assign ifc.hold = hold_r[2];

    sci_event_counter #(.NUM_DIGITS(11), .MANT_DIGITS(2)) u_a (.clk(clk), .rst(rst_r[0]), .bus(ifa));
    sci_event_counter #(.NUM_DIGITS(4),  .MANT_DIGITS(2)) u_b (.clk(clk), .rst(rst_r[1]), .bus(ifb));
    sci_event_counter #(.NUM_DIGITS(5),  .MANT_DIGITS(3)) u_c (.clk(clk), .rst(rst_r[2]), .bus(ifc));

    logic [63:0] cnt_o[3], mant_o[3];
    logic [3:0]  exp_o[3];
    logic        ovf_o[3], upd_o[3];

    assign cnt_o[0] = 64'(ifa.count_bcd); assign mant_o[0] = 64'(ifa.mant_bcd);
    assign cnt_o[1] = 64'(ifb.count_bcd); assign mant_o[1] = 64'(ifb.mant_bcd);
    assign cnt_o[2] = 64'(ifc.count_bcd); assign mant_o[2] = 64'(ifc.mant_bcd);
    assign exp_o[0] = ifa.exp_bcd; assign ovf_o[0] = ifa.ovf; assign upd_o[0] = ifa.disp_upd;
    assign exp_o[1] = ifb.exp_bcd; assign ovf_o[1] = ifb.ovf; assign upd_o[1] = ifb.disp_upd;
    assign exp_o[2] = ifc.exp_bcd; assign ovf_o[2] = ifc.ovf; assign upd_o[2] = ifc.disp_upd;

    // Model state, plain decimal integers.
    longint      cnt_m[3];
    logic [63:0] mant_m[3];
    int          exp_m[3];
    bit          ovf_m[3], upd_m[3];

    typedef struct {
        int          i;
        string       tag;
        logic [63:0] cnt;
        logic [63:0] mant;
        int          ex;
        bit          ov;
        bit          upd;
    } exp_t;

    exp_t sb[$];
    int   n_chk, n_pass;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got %0h want %0h", tag, got, want);
    endtask

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int k = 0; k < n; k++) p *= 10;
        return p;
    endfunction

    function automatic logic [63:0] to_bcd(input longint v);
        logic [63:0] r = '0;
        longint t = v;
        for (int k = 0; k < 16; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic disp(input longint c, input int md, output logic [63:0] mb, output int e);
        int d = 0;
        longint t = c;
        while (t > 0) begin d++; t = t / 10; end
        e  = (d > md) ? d - md : 0;
        mb = to_bcd((c / pow10(e)) % pow10(md));
    endtask

    task automatic model_edge();
        logic [63:0] mb;
        int e;
        for (int i = 0; i < 3; i++) begin
            if (!rst_r[i] || clr_r[i]) begin
                cnt_m[i] = 0; ovf_m[i] = 0; mant_m[i] = '0; exp_m[i] = 0; upd_m[i] = 0;
            end else begin
                if (hold_r[i]) upd_m[i] = 0;
                else begin
                    disp(cnt_m[i], MD[i], mb, e);
                    upd_m[i]  = (mb != mant_m[i]) || (e != exp_m[i]);
                    mant_m[i] = mb;
                    exp_m[i]  = e;
                end
                if (inc_r[i]) begin
                    if (cnt_m[i] == pow10(ND[i]) - 1) begin
                        ovf_m[i] = 1;
`ifndef SCI_CNT_SATURATE_EN
                        cnt_m[i] = 0;
`endif
                    end else cnt_m[i]++;
                end
            end
        end
    endtask

    task automatic step(input int i, input bit r, input bit c, input bit n, input bit h,
                        input bit ck, input string tag);
        exp_t x;
        for (int j = 0; j < 3; j++) begin
            rst_r[j] = 1'b1; clr_r[j] = 1'b0; inc_r[j] = 1'b0; hold_r[j] = 1'b0;
        end
        rst_r[i] = r; clr_r[i] = c; inc_r[i] = n; hold_r[i] = h;
        @(posedge clk);
        model_edge();
        if (ck) begin
            x.i = i; x.tag = tag; x.cnt = to_bcd(cnt_m[i]); x.mant = mant_m[i];
            x.ex = exp_m[i]; x.ov = ovf_m[i]; x.upd = upd_m[i];
            sb.push_back(x);
        end
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk({x.tag, ".cnt"},  cnt_o[x.i],        x.cnt);
            chk({x.tag, ".mant"}, mant_o[x.i],       x.mant);
            chk({x.tag, ".exp"},  64'(exp_o[x.i]),   64'(x.ex));
            chk({x.tag, ".ovf"},  64'(ovf_o[x.i]),   64'(x.ov));
            chk({x.tag, ".upd"},  64'(upd_o[x.i]),   64'(x.upd));
        end
    endtask

    task automatic incs(input int i, input int n, input bit h, input string tag);
        for (int k = 0; k < n; k++) step(i, 1'b1, 1'b0, 1'b1, h, k == n - 1, tag);
    endtask

    task automatic idle(input int i, input bit ck, input string tag);
        step(i, 1'b1, 1'b0, 1'b0, 1'b0, ck, tag);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        for (int j = 0; j < 3; j++) begin
            rst_r[j] = 1'b0; inc_r[j] = 1'b0; clr_r[j] = 1'b0; hold_r[j] = 1'b0;
            cnt_m[j] = 0; mant_m[j] = '0; exp_m[j] = 0; ovf_m[j] = 0; upd_m[j] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) step(j, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reset");

        // Default geometry: 99 -> 100 crossing into exponent 1.
        incs(0, 99, 1'b0, "a99");   idle(0, 1'b1, "a99d");
        incs(0, 1,  1'b0, "a100");  idle(0, 1'b1, "a100d");

        // Hold at 57 while counting to 107, then release.
        step(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "aclr");
        incs(0, 57, 1'b0, "a57");   idle(0, 1'b1, "a57d");
        incs(0, 50, 1'b1, "ahold");
        step(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "aholdi");
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "arel");
        step(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "aclrhold");

        // clr beats inc at 1234.
        incs(0, 1234, 1'b0, "a1234"); idle(0, 1'b1, "a1234d");
        step(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "aclrinc");
        idle(0, 1'b1, "aclrincd");

        // Reset during a full carry ripple 0999 -> 1000.
        incs(0, 999, 1'b0, "a999");
        step(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "arstcarry");

        // rst pulse between edges must be ignored.
        incs(0, 5, 1'b0, "a5"); idle(0, 1'b0, "");
        #2 rst_r[0] = 1'b0;
        #2 rst_r[0] = 1'b1;
        idle(0, 1'b1, "aglitch");

        // Four digits: terminal count and overflow.
        incs(1, 9999, 1'b0, "b9999"); idle(1, 1'b1, "b9999d");
        incs(1, 1, 1'b0, "bovf");     idle(1, 1'b1, "bovfd");
        incs(1, 3, 1'b0, "bpost");
        step(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "bclr");

        // Three-digit mantissa: 45678 -> 456 E2.
        incs(2, 45678, 1'b0, "c45678"); idle(2, 1'b1, "c45678d");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
